// File: rtl/adc_serial_tx_pkg.sv
// Shared definitions for the ADC serial transmitter and the ADC reader side:
// FSM state encoding and default frame geometry.
package adc_serial_tx_pkg;

  localparam int N_ADC_DEFAULT      = 12;
  localparam int LEAD_ZEROS_DEFAULT = 4;
  localparam int ERR_COUNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

endpackage : adc_serial_tx_pkg

// File: rtl/adc_serial_tx_sync.sv
// Multi-flop synchronizer followed by one edge-detect flop; produces
// single-cycle rise/fall pulses in the clk domain.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule : sync_edge_det

// File: rtl/adc_serial_tx.sv
// Serial transmitter of ADC samples framed by CS/Clock_Muestreo from the reader.
// Optional saturating error counter enabled by defining ADC_TX_ERRCNT_EN.
module adc_serial_tx
  import adc_serial_tx_pkg::*;
#(
  parameter int N_ADC       = N_ADC_DEFAULT,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock_In,
  input  logic                   Reset,
  input  logic                   CS,
  input  logic                   Clock_Muestreo,
  input  logic [N_ADC-1:0]       sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   data_ADC,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun,
  output logic                   abort,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int F      = LEAD_ZEROS + N_ADC;
  localparam int CNT_W  = $clog2(F + 1);
  localparam int WARM_N = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM_N + 1);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_fall, sclk_level_unused, sclk_rise_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk      (clock_In),
    .rst_n    (Reset),
    .async_in (CS),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk      (clock_In),
    .rst_n    (Reset),
    .async_in (Clock_Muestreo),
    .level    (sclk_level_unused),
    .rise     (sclk_rise_unused),
    .fall     (sclk_fall)
  );

  tx_state_e          state_q, state_d;
  logic [F-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_ADC-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [N_ADC-1:0]   last_q, last_d;
  logic               frame_done_q, frame_done_d;
  logic               underrun_q, underrun_d;
  logic               abort_q, abort_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               armed_q, armed_d;
  logic               warm_done;
  logic               load_frame;
  logic [N_ADC-1:0]   frame_sample;

  // The synchronizer resets CS high, so a CS held low across reset release
  // looks like a falling edge; frames are only armed once CS is seen high.
  assign warm_done = (warm_q == WARM_W'(WARM_N));

  always_comb begin
    warm_d  = warm_done ? warm_q : warm_q + WARM_W'(1);
    armed_d = armed_q | (warm_done & cs_level);
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;
    load_frame   = 1'b0;
    frame_sample = hold_full_q ? hold_q : last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          load_frame  = 1'b1;
          state_d     = ST_SHIFT;
          shift_d     = F'(frame_sample);
          last_d      = frame_sample;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          underrun_d  = ~hold_full_q;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (sclk_fall) begin
          shift_d = {shift_q[F-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(F - 1)) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A frame load frees the holding register in the same cycle, so a
    // concurrent write lands in it instead of being stalled.
    sample_ready = ~hold_full_q | load_frame;
    if (sample_valid && sample_ready) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock_In or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
      warm_q       <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
      warm_q       <= warm_d;
      armed_q      <= armed_d;
    end
  end

  assign data_ADC   = (state_q == ST_SHIFT) ? shift_q[F-1] : 1'b0;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign abort      = abort_q;

`ifdef ADC_TX_ERRCNT_EN
  logic [ERR_COUNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((underrun_d || abort_d) && (err_q != {ERR_COUNT_W{1'b1}})) begin
      err_d = err_q + ERR_COUNT_W'(1);
    end
  end

  always_ff @(posedge clock_In or negedge Reset) begin
    if (!Reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule : adc_serial_tx

// File: tb/tb_adc_serial_tx.sv
// Directed self-checking bench for adc_serial_tx with a bit-level scoreboard;
// expected error counts follow ADC_TX_ERRCNT_EN when it is defined.
module tb_adc_serial_tx;

`ifdef ADC_TX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock_In = 1'b0;
  logic        Reset = 1'b0;
  logic        CS = 1'b1;
  logic        Clock_Muestreo = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, data_ADC, busy, frame_done, underrun, abort;
  logic [7:0]  err_count;

  adc_serial_tx dut (
    .clock_In       (clock_In),
    .Reset          (Reset),
    .CS             (CS),
    .Clock_Muestreo (Clock_Muestreo),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .data_ADC       (data_ADC),
    .busy           (busy),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .abort          (abort),
    .err_count      (err_count)
  );

  always #5 clock_In = ~clock_In;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_n = 0, ur_n = 0, ab_n = 0;
  int exp_err = 0;
  logic exp_bits[$];

  always @(posedge clock_In) begin
    if (frame_done) fd_n++;
    if (underrun)   ur_n++;
    if (abort)      ab_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bump(input int e);
    return ERR_EN ? ((e < 255) ? e + 1 : 255) : 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_In);
  endtask

  task automatic write_sample(input logic [11:0] v);
    int k = 0;
    while (!sample_ready && k < 20) begin
      @(negedge clock_In);
      k++;
    end
    check("ready_before_write", sample_ready, 1);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clock_In);
    sample_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [11:0] v);
    logic [15:0] fr;
    fr = {4'h0, v};
    for (int i = 15; i >= 0; i--) exp_bits.push_back(fr[i]);
  endtask

  task automatic start_frame(input logic [11:0] v);
    push_frame(v);
    CS = 1'b0;
    wait_cyc(6);
  endtask

  // One Clock_Muestreo period per bit; data is sampled mid high phase.
  task automatic shift_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      Clock_Muestreo = 1'b1;
      wait_cyc(3);
      check("sb_not_empty", exp_bits.size() > 0, 1);
      b = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
      check($sformatf("data_bit%0d", i), data_ADC, b);
      wait_cyc(3);
      Clock_Muestreo = 1'b0;
      wait_cyc(6);
    end
  endtask

  task automatic end_frame();
    CS = 1'b1;
    wait_cyc(6);
  endtask

  initial begin
    int fd0, ur0, ab0;
    bit got;

    // Reset state
    wait_cyc(3);
    check("rst_data", data_ADC, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_err", err_count, 0);
    check("rst_pulses", {frame_done, underrun, abort}, 0);
    Reset = 1'b1;
    wait_cyc(6);

    // Empty holding register after reset: zero frame with underrun
    fd0 = fd_n; ur0 = ur_n;
    start_frame(12'h000);
    check("t1_busy", busy, 1);
    shift_bits(16);
    check("t1_done", fd_n - fd0, 1);
    check("t1_underrun", ur_n - ur0, 1);
    exp_err = bump(exp_err);
    check("t1_err", err_count, exp_err);
    check("t1_data_done", data_ADC, 0);
    end_frame();
    check("t1_idle", busy, 0);

    // Normal frame 12'hA5C
    write_sample(12'hA5C);
    check("t2_ready_full", sample_ready, 0);
    fd0 = fd_n; ur0 = ur_n;
    start_frame(12'hA5C);
    check("t2_ready_freed", sample_ready, 1);
    shift_bits(16);
    check("t2_done", fd_n - fd0, 1);
    check("t2_no_underrun", ur_n - ur0, 0);
    check("t2_busy_done", busy, 1);
    check("t2_err", err_count, exp_err);
    end_frame();
    check("t2_idle", busy, 0);

    // Abort after 7 bits, then repeat of the consumed sample with underrun
    write_sample(12'hFFF);
    ab0 = ab_n;
    start_frame(12'hFFF);
    shift_bits(7);
    CS = 1'b1;
    wait_cyc(6);
    check("t3_abort", ab_n - ab0, 1);
    check("t3_data", data_ADC, 0);
    check("t3_busy", busy, 0);
    exp_err = bump(exp_err);
    check("t3_err_abort", err_count, exp_err);
    exp_bits.delete();
    fd0 = fd_n; ur0 = ur_n;
    start_frame(12'hFFF);
    shift_bits(16);
    check("t3_repeat_done", fd_n - fd0, 1);
    check("t3_underrun", ur_n - ur0, 1);
    exp_err = bump(exp_err);
    check("t3_err_underrun", err_count, exp_err);
    end_frame();

    // Write accepted in the frame-load cycle
    write_sample(12'h456);
    ur0 = ur_n;
    push_frame(12'h456);
    sample_in    = 12'h123;
    sample_valid = 1'b1;
    CS           = 1'b0;
    got          = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock_In);
      if (sample_ready) got = 1'b1;
    end
    check("t4_ready_in_load", got, 1);
    @(negedge clock_In);
    sample_valid = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_hold_full", sample_ready, 0);
    wait_cyc(4);
    shift_bits(16);
    end_frame();
    start_frame(12'h123);
    shift_bits(16);
    end_frame();
    check("t4_no_underrun", ur_n - ur0, 0);

    // Reset mid-frame at bit 9, CS held low across release
    write_sample(12'h5A5);
    start_frame(12'h5A5);
    shift_bits(9);
    Reset = 1'b0;
    #1;
    check("t5_data", data_ADC, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", sample_ready, 1);
    check("t5_err", err_count, 0);
    check("t5_pulses", {frame_done, underrun, abort}, 0);
    exp_err = 0;
    exp_bits.delete();
    wait_cyc(3);
    fd0 = fd_n; ur0 = ur_n; ab0 = ab_n;
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Clock_Muestreo = 1'b1;
      wait_cyc(6);
      Clock_Muestreo = 1'b0;
      wait_cyc(6);
    end
    check("t5_no_frame_busy", busy, 0);
    check("t5_no_pulses", (fd_n - fd0) + (ur_n - ur0) + (ab_n - ab0), 0);
    end_frame();
    write_sample(12'h3C3);
    fd0 = fd_n; ur0 = ur_n;
    start_frame(12'h3C3);
    shift_bits(16);
    check("t5_frame_done", fd_n - fd0, 1);
    check("t5_no_underrun", ur_n - ur0, 0);
    end_frame();

    // 300 aborts: counter saturates (or stays 0 without the counter)
    ab0 = ab_n;
    for (int i = 0; i < 300; i++) begin
      CS = 1'b0;
      wait_cyc(5);
      CS = 1'b1;
      wait_cyc(5);
      exp_err = bump(bump(exp_err));
    end
    check("t6_aborts", ab_n - ab0, 300);
    check("t6_err_sat", err_count, exp_err);
    check("t6_err_value", exp_err, ERR_EN ? 255 : 0);

    check("sb_drained", exp_bits.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adc_serial_tx
